// File: rtl/rs_ram_pkg.sv
// Shared definitions for the working-RAM arbiter: default geometry, FSM state encoding,
// read latency of the attached RAM, and the encoding of the last round-robin winner.
package rs_ram_pkg;

  localparam int AW_DEF     = 5;
  localparam int DW_DEF     = 16;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  // last-winner flag: 0 = A won the most recent grant, 1 = B did
  localparam logic WIN_A = 1'b0;
  localparam logic WIN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a single requester always wins; on a tie the side that did
// not win last time is chosen. Purely combinational.
module rr_arb2
  import rs_ram_pkg::*;
(
  input  logic [1:0] req,   // [0] = A, [1] = B
  input  logic       last,  // WIN_A / WIN_B
  output logic [1:0] gnt
);

  // one-hot pick; a tie goes to the side opposite the previous winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == WIN_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port working RAM between requester A (syndrome/write-back) and
// requester B (Euclid engine). Per-access round-robin, optional locked bursts capped at
// LOCK_MAX grants, read data returned RAM_RD_LAT cycles after the grant with a valid.
module ram_access_arbiter
  import rs_ram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,

  output logic          ram_ren,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int            CW          = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C  = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    arb_gnt;
  logic          at_limit;

  // read-issue pipelines, depth matches the RAM's registered read latency
  logic [RAM_RD_LAT-1:0] a_pipe_q, b_pipe_q;

  rr_arb2 u_arb (
    .req  ({b_req, a_req}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  assign at_limit = (cnt_q == LOCK_MAX_C);

  // state register: FSM state, last round-robin winner and burst length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= WIN_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: lock entry/exit, burst counting and forced release at LOCK_MAX
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (a_gnt) begin
      last_d = WIN_A;
    end else if (b_gnt) begin
      last_d = WIN_B;
    end
    case (state_q)
      ST_IDLE: begin
        if (a_gnt && a_lock) begin
          state_d = ST_OWN_A;
          cnt_d   = CNT_ONE;
        end else if (b_gnt && b_lock) begin
          state_d = ST_OWN_B;
          cnt_d   = CNT_ONE;
        end
      end
      ST_OWN_A: begin
        if (at_limit) begin
          // burst exhausted: hand the next tie to B
          state_d = ST_IDLE;
          cnt_d   = '0;
          last_d  = WIN_A;
        end else if (!a_lock) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (a_gnt) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_OWN_B: begin
        if (at_limit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          last_d  = WIN_B;
        end else if (!b_lock) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (b_gnt) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs: grants from state + requests, and the RAM port muxed from the winner.
  // Grants are held off while reset is asserted so the RAM sees no access.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        a_gnt = arb_gnt[0];
        b_gnt = arb_gnt[1];
      end
      ST_OWN_A: a_gnt = a_req && !at_limit;
      ST_OWN_B: b_gnt = b_req && !at_limit;
      default: begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
      end
    endcase
    a_gnt = a_gnt & rst_n;
    b_gnt = b_gnt & rst_n;

    ram_ren  = (a_gnt & ~a_we) | (b_gnt & ~b_we);
    ram_wen  = (a_gnt &  a_we) | (b_gnt &  b_we);
    ram_addr = '0;
    ram_din  = '0;
    if (a_gnt) begin
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (b_gnt) begin
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  // read-valid pipelines; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pipe_q <= '0;
      b_pipe_q <= '0;
    end else begin
      a_pipe_q <= (a_pipe_q << 1) | RAM_RD_LAT'(a_gnt & ~a_we);
      b_pipe_q <= (b_pipe_q << 1) | RAM_RD_LAT'(b_gnt & ~b_we);
    end
  end

  assign a_rvalid = a_pipe_q[RAM_RD_LAT-1];
  assign b_rvalid = b_pipe_q[RAM_RD_LAT-1];

  // the RAM bus floats between reads; only pass it through with a valid
  assign a_rdata = a_rvalid ? ram_dout : '0;
  assign b_rdata = b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: a default instance (LOCK_MAX=8) and a LOCK_MAX=4
// instance share stimulus, each with its own behavioural registered-read RAM.
module tb_ram_access_arbiter;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_ren, ram_wen;
  logic [DW-1:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic          a_gnt4, a_rvalid4, b_gnt4, b_rvalid4, ram_ren4, ram_wen4;
  logic [DW-1:0] a_rdata4, b_rdata4, ram_din4, ram_dout4;
  logic [AW-1:0] ram_addr4;

  int n_cmp = 0;
  int n_bad = 0;

  ram_access_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  ram_access_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt4), .a_rvalid(a_rvalid4), .a_rdata(a_rdata4),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt4), .b_rvalid(b_rvalid4), .b_rdata(b_rdata4),
    .ram_ren(ram_ren4), .ram_wen(ram_wen4), .ram_addr(ram_addr4), .ram_din(ram_din4),
    .ram_dout(ram_dout4)
  );

  // behavioural RAMs: registered read, a garbage pattern on the bus when not reading
  logic [DW-1:0] mem  [32];
  logic [DW-1:0] mem4 [32];
  logic [DW-1:0] rd_q, rd_q4;
  logic          rd_v, rd_v4;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    rd_v <= ram_ren;
    if (ram_ren) rd_q <= mem[ram_addr];
    if (ram_wen4) mem4[ram_addr4] <= ram_din4;
    rd_v4 <= ram_ren4;
    if (ram_ren4) rd_q4 <= mem4[ram_addr4];
  end

  assign ram_dout  = rd_v  ? rd_q  : 16'hDEAD;
  assign ram_dout4 = rd_v4 ? rd_q4 : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic idle_inputs();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // T1: reset with random inputs keeps every output at 0
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_a(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom));
      drive_b(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 16'($urandom));
      #1;
      chk("rst_a_gnt", a_gnt, 0);       chk("rst_b_gnt", b_gnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
      chk("rst_ram_ren", ram_ren, 0);   chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ram_addr", ram_addr, 0); chk("rst_ram_din", ram_din, 0);
      chk("rst4_a_gnt", a_gnt4, 0);     chk("rst4_b_gnt", b_gnt4, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(1'b1, 1'b0, 1'b0, 5'd3, '0);
    drive_b(1'b1, 1'b0, 1'b0, 5'd7, '0);
    #1;
    chk("t1_a_first", a_gnt, 1);
    chk("t1_b_stall", b_gnt, 0);

    // T2: A writes 3 <= BEEF, B reads it back on the next grant
    @(negedge clk);
    drive_a(1'b1, 1'b1, 1'b0, 5'd3, 16'hBEEF);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t2_a_gnt", a_gnt, 1);
    chk("t2_ram_wen", ram_wen, 1);
    chk("t2_ram_addr", ram_addr, 3);
    chk("t2_ram_din", ram_din, 16'hBEEF);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b1, 1'b0, 1'b0, 5'd3, '0);
    #1;
    chk("t2_b_gnt", b_gnt, 1);
    chk("t2_ram_ren", ram_ren, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t2_b_rvalid", b_rvalid, 1);
    chk("t2_b_rdata", b_rdata, 16'hBEEF);
    chk("t2_a_rvalid", a_rvalid, 0);

    // T3: continuous tie alternates A,B,A,B with rvalid one cycle behind
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b0, 1'b0, 5'd3, '0);
      drive_b(1'b1, 1'b0, 1'b0, 5'd7, '0);
      #1;
      chk("t3_a_gnt", a_gnt, (i % 2 == 0));
      chk("t3_b_gnt", b_gnt, (i % 2 == 1));
      chk("t3_ram_addr", ram_addr, (i % 2 == 0) ? 3 : 7);
      chk("t3_a_rvalid", a_rvalid, (i > 0) && (i % 2 == 1));
      chk("t3_b_rvalid", b_rvalid, (i > 0) && (i % 2 == 0));
      chk("t3_a_rdata", a_rdata, ((i > 0) && (i % 2 == 1)) ? 16'hBEEF : 16'h0);
    end

    // T4: A locked write burst to 0..5, B stalled until the cycle after the last grant
    pulse_rst();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b1, (i < 5), 5'(i), 16'h1000 + 16'(i));
      drive_b(1'b1, 1'b0, 1'b0, 5'd0, '0);
      #1;
      chk("t4_a_gnt", a_gnt, 1);
      chk("t4_b_gnt", b_gnt, 0);
      chk("t4_ram_addr", ram_addr, i);
      chk("t4_ram_din", ram_din, 16'h1000 + i);
    end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t4_b_gnt_after", b_gnt, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t4_b_rvalid", b_rvalid, 1);
    chk("t4_b_rdata", b_rdata, 16'h1000);

    // T5: lock held 10 cycles with B waiting: LOCK_MAX grants, one dead cycle, then B
    pulse_rst();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b0, 1'b1, 5'd1, '0);
      drive_b(1'b1, 1'b0, 1'b0, 5'd2, '0);
      #1;
      chk("t5_m8_a_gnt", a_gnt, (i < 8));
      chk("t5_m8_b_gnt", b_gnt, (i == 9));
      if (i <= 5) begin
        chk("t5_m4_a_gnt", a_gnt4, (i < 4));
        chk("t5_m4_b_gnt", b_gnt4, (i == 5));
      end
    end

    // T5b: owner idles with lock held -> nobody granted, count frozen; unlock releases
    pulse_rst();
    @(negedge clk);
    drive_a(1'b1, 1'b0, 1'b1, 5'd1, '0);
    drive_b(1'b1, 1'b0, 1'b0, 5'd2, '0);
    #1;
    chk("t5b_a_gnt", a_gnt, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_a(1'b0, 1'b0, 1'b1, 5'd1, '0);
      #1;
      chk("t5b_hold_a", a_gnt, 0);
      chk("t5b_hold_b", b_gnt, 0);
    end
    @(negedge clk);
    drive_a(1'b1, 1'b0, 1'b0, 5'd1, '0);
    #1;
    chk("t5b_unlock_a", a_gnt, 1);
    chk("t5b_unlock_b", b_gnt, 0);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t5b_b_gnt", b_gnt, 1);

    // T6: reset lands after an A read is issued but before its data returns
    pulse_rst();
    @(negedge clk);
    drive_a(1'b1, 1'b0, 1'b0, 5'd3, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("t6_a_gnt", a_gnt, 1);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("t6_no_rvalid", a_rvalid, 0);
      chk("t6_no_gnt", a_gnt, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(1'b1, 1'b0, 1'b0, 5'd3, '0);
    drive_b(1'b1, 1'b0, 1'b0, 5'd7, '0);
    #1;
    chk("t6_tie_a", a_gnt, 1);
    chk("t6_tie_b", b_gnt, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t6_a_rvalid", a_rvalid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
